// File: rtl/sobel_window_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for the Sobel window generator.
// The generator owns the slave side; the pixel source / window consumer is the master.
interface sobel_window_gen_if #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;

  logic              win_valid;
  logic              win_last;
  logic [XW-1:0]     win_x;
  logic [YW-1:0]     win_y;
  logic [DATA_W-1:0] data00, data01, data02;
  logic [DATA_W-1:0] data10, data11, data12;
  logic [DATA_W-1:0] data20, data21, data22;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  win_valid, win_last, win_x, win_y,
    input  data00, data01, data02, data10, data11, data12, data20, data21, data22
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output win_valid, win_last, win_x, win_y,
    output data00, data01, data02, data10, data11, data12, data20, data21, data22
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting 3x3
// register window, emitting one registered window per interior pixel.
module sobel_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
) (
  input logic               clk,
  input logic               reset_n,
  sobel_window_gen_if.slave win_if
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [XW-1:0]     x_cnt, cur_x, nxt_x;
  logic [YW-1:0]     y_cnt, cur_y, nxt_y;
  logic              accept;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] lb1 [IMG_W];  // line y-1
  logic [DATA_W-1:0] lb2 [IMG_W];  // line y-2
  logic [DATA_W-1:0] win [3][3];
  logic              valid_q, last_q;
  logic [XW-1:0]     wx_q;
  logic [YW-1:0]     wy_q;

  // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    accept = win_if.pix_valid;
    cur_x  = win_if.pix_sof ? '0 : x_cnt;
    cur_y  = win_if.pix_sof ? '0 : y_cnt;
    nxt_x  = cur_x + XW'(1);
    nxt_y  = cur_y;
    if (cur_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
    end
    rd1 = lb1[cur_x];
    rd2 = lb2[cur_x];
  end

  // NOTE: line-buffer storage is deliberately not reset; stale rows are masked by the y>=2 gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_x] <= win_if.pix_data;
      lb2[cur_x] <= rd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (accept) begin
        x_cnt <= nxt_x;
        y_cnt <= nxt_y;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            win[r][c] <= win[r][c+1];
        win[0][2] <= rd2;
        win[1][2] <= rd1;
        win[2][2] <= win_if.pix_data;
        // The x/y gate hides columns from the previous line and rows from the previous frame.
        if (cur_x >= X_TWO && cur_y >= Y_TWO) begin
          valid_q <= 1'b1;
          last_q  <= (cur_x == X_LAST) && (cur_y == Y_LAST);
          wx_q    <= cur_x - XW'(1);
          wy_q    <= cur_y - YW'(1);
        end
      end
    end
  end

  assign win_if.win_valid = valid_q;
  assign win_if.win_last  = last_q;
  assign win_if.win_x     = wx_q;
  assign win_if.win_y     = wy_q;
  assign win_if.data00    = win[0][0];
  assign win_if.data01    = win[0][1];
  assign win_if.data02    = win[0][2];
  assign win_if.data10    = win[1][0];
  assign win_if.data11    = win[1][1];
  assign win_if.data12    = win[1][2];
  assign win_if.data20    = win[2][0];
  assign win_if.data21    = win[2][1];
  assign win_if.data22    = win[2][2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on an 8x6 image: a frame-image
// reference model predicts every window, plus a Sobel check on a vertical step.
module tb_sobel_window_gen;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [8:0][DATA_W-1:0] d;  // d[r*3+c] = dataRC
  } win_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state: current frame image and raster position.
  int                pos = 0;
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  win_t              ref_q [$];

  sobel_window_gen_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) ifc ();

  sobel_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .win_if  (ifc)
  );

  always #5 clk = ~clk;

  function automatic win_t sample();
    win_t w;
    w.valid = ifc.win_valid;
    w.last  = ifc.win_last;
    w.x     = ifc.win_x;
    w.y     = ifc.win_y;
    w.d[0] = ifc.data00; w.d[1] = ifc.data01; w.d[2] = ifc.data02;
    w.d[3] = ifc.data10; w.d[4] = ifc.data11; w.d[5] = ifc.data12;
    w.d[6] = ifc.data20; w.d[7] = ifc.data21; w.d[8] = ifc.data22;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input int x, input int y);
    return DATA_W'((y << 4) | x);
  endfunction

  // One clock of stimulus; returns what the DUT showed after the edge and what the model predicts.
  task automatic step(input logic v, input logic s, input logic [DATA_W-1:0] d,
                      output win_t obs, output win_t exp);
    int px, py;
    @(negedge clk);
    ifc.pix_valid = v;
    ifc.pix_sof   = s;
    ifc.pix_data  = d;
    @(posedge clk);
    exp = '0;
    if (v) begin
      if (s) pos = 0;
      px = pos % IMG_W;
      py = pos / IMG_W;
      img[py][px] = d;
      if (px >= 2 && py >= 2) begin
        exp.valid = 1'b1;
        exp.last  = (pos == NPIX - 1);
        exp.x     = XW'(px - 1);
        exp.y     = YW'(py - 1);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp.d[r*3+c] = img[py-2+r][px-2+c];
      end
      pos = (pos + 1) % NPIX;
    end
    #1 obs = sample();
  endtask

  task automatic test_reset();
    win_t o, e;
    ifc.pix_valid = 1'b0;
    ifc.pix_sof   = 1'b0;
    ifc.pix_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sample() !== win_t'(0)) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", sample());
    end
    @(negedge clk) reset_n = 1'b1;
    pos = 0;
    repeat (3) begin
      step(1'b0, 1'b0, '0, o, e);
      total++;
      if (o.valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle_valid got=%b want=0", o.valid);
      end
    end
  endtask

  task automatic test_frame();
    win_t o, e;
    win_t got [$];
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL frame_win i=%0d got=%h want=%h", i, o, e);
      end
      if (e.valid) ref_q.push_back(e);
      if (o.valid) got.push_back(o);
    end
    total++;
    if (got.size() != NWIN) begin
      bad++;
      $display("FAIL frame_count got=%0d want=%0d", got.size(), NWIN);
    end
    if (got.size() > 0) begin
      total++;
      if (got[0].x !== 3'd1 || got[0].y !== 3'd1 || got[0].d[0] !== 16'h00 ||
          got[0].d[2] !== 16'h02 || got[0].d[4] !== 16'h11 || got[0].d[6] !== 16'h20 ||
          got[0].d[8] !== 16'h22 || got[0].last !== 1'b0) begin
        bad++;
        $display("FAIL frame_first got=%h want x=1 y=1 d00=00 d02=02 d11=11 d20=20 d22=22", got[0]);
      end
      total++;
      if (got[$].last !== 1'b1 || got[$].x !== 3'd6 || got[$].y !== 3'd4 ||
          got[$].d[8] !== 16'h57) begin
        bad++;
        $display("FAIL frame_last got=%h want last=1 x=6 y=4 d22=57", got[$]);
      end
    end
  endtask

  task automatic test_gaps();
    win_t o, e;
    win_t got [$];
    int   gap;
    for (int i = 0; i < NPIX; i++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), o, e);
        total++;
        if (o.valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_valid i=%0d got=%b want=0", i, o.valid);
        end
      end
      step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL gap_win i=%0d got=%h want=%h", i, o, e);
      end
      if (o.valid) got.push_back(o);
    end
    total++;
    if (got.size() != NWIN) begin
      bad++;
      $display("FAIL gap_count got=%0d want=%0d", got.size(), NWIN);
    end
    for (int k = 0; k < got.size() && k < ref_q.size(); k++) begin
      total++;
      if (got[k] !== ref_q[k]) begin
        bad++;
        $display("FAIL gap_seq k=%0d got=%h want=%h", k, got[k], ref_q[k]);
      end
    end
  endtask

  task automatic test_sof_mid();
    win_t o, e;
    int   early;
    win_t first;
    logic have_first;
    early = 0;
    have_first = 1'b0;
    first = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W) | 16'h0100, o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL sofmid_partial i=%0d got=%h want=%h", i, o, e);
      end
    end
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL sofmid_win i=%0d got=%h want=%h", i, o, e);
      end
      if (i < 2 * IMG_W + 2 && o.valid) early++;
      if (o.valid && !have_first) begin
        first = o;
        have_first = 1'b1;
      end
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL sofmid_early got=%0d want=0", early);
    end
    total++;
    if (!have_first || first.d[0] !== 16'h0000 || first.x !== 3'd1 || first.y !== 3'd1) begin
      bad++;
      $display("FAIL sofmid_first got=%h want d00=0000 x=1 y=1", first);
    end
  endtask

  task automatic test_reset_mid();
    win_t o, e;
    win_t got [$];
    for (int i = 0; i < 30; i++) step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W), o, e);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (sample() !== win_t'(0)) begin
      bad++;
      $display("FAIL resetmid_async got=%h want=0", sample());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    pos = 0;
    repeat (3) step(1'b0, 1'b0, '0, o, e);
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i == 0, pat(i % IMG_W, i / IMG_W), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL resetmid_win i=%0d got=%h want=%h", i, o, e);
      end
      if (o.valid) got.push_back(o);
    end
    total++;
    if (got.size() != NWIN) begin
      bad++;
      $display("FAIL resetmid_count got=%0d want=%0d", got.size(), NWIN);
    end
  endtask

  task automatic test_back_to_back();
    win_t o, e;
    win_t got [$];
    for (int i = 0; i < 2 * NPIX; i++) begin
      step(1'b1, i == 0, pat(i % IMG_W, (i % NPIX) / IMG_W), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL b2b_win i=%0d got=%h want=%h", i, o, e);
      end
      if (o.valid) got.push_back(o);
    end
    total++;
    if (got.size() != 2 * NWIN) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", got.size(), 2 * NWIN);
    end
    for (int k = 0; k < got.size() && ref_q.size() == NWIN; k++) begin
      total++;
      if (got[k] !== ref_q[k % NWIN]) begin
        bad++;
        $display("FAIL b2b_seq k=%0d got=%h want=%h", k, got[k], ref_q[k % NWIN]);
      end
    end
  endtask

  task automatic test_random();
    win_t o, e;
    int   nwin;
    nwin = 0;
    for (int i = 0; i < NPIX; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), o, e);
        total++;
        if (o.valid !== 1'b0) begin
          bad++;
          $display("FAIL rand_gap i=%0d got=%b want=0", i, o.valid);
        end
      end
      step(1'b1, i == 0, DATA_W'($urandom), o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL rand_win i=%0d got=%h want=%h", i, o, e);
      end
      if (o.valid) nwin++;
    end
    total++;
    if (nwin != NWIN) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d", nwin, NWIN);
    end
  endtask

  task automatic test_sobel();
    win_t o, e;
    int   v [9];
    int   gx, gy, mag, nwin;
    logic sdata, want;
    nwin = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i == 0, ((i % IMG_W) < 4) ? 16'h0000 : 16'h4000, o, e);
      total++;
      if (o.valid !== e.valid || (e.valid && o !== e)) begin
        bad++;
        $display("FAIL sobel_win i=%0d got=%h want=%h", i, o, e);
      end
      if (o.valid) begin
        nwin++;
        for (int k = 0; k < 9; k++) v[k] = int'(o.d[k]);
        gx  = (v[2] + 2 * v[5] + v[8]) - (v[0] + 2 * v[3] + v[6]);
        gy  = (v[6] + 2 * v[7] + v[8]) - (v[0] + 2 * v[1] + v[2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sdata = (mag > 32000);
        want  = (o.x == 3 || o.x == 4);
        total++;
        if (sdata !== want) begin
          bad++;
          $display("FAIL sobel_edge x=%0d y=%0d sum=%0d got=%b want=%b", o.x, o.y, mag, sdata, want);
        end
      end
    end
    total++;
    if (nwin != NWIN) begin
      bad++;
      $display("FAIL sobel_count got=%0d want=%0d", nwin, NWIN);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_sobel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 window generator that sits upstream of the Sobel edge stage.
- Accepts one 16-bit grayscale pixel per valid cycle in raster order.
- Buffers the two previous lines and presents a registered 3x3 neighbourhood (data00..data22) with a valid strobe and centre coordinates, ready to feed the Sobel filter directly.
- Border pixels produce no window; the downstream stage treats them as non-edge.

Parameters:
- DATA_W, 16, pixel width in bits.
- IMG_W, 320, pixels per line (>=3).
- IMG_H, 240, lines per frame (>=3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pix_data is valid this cycle; no backpressure.
- pix_sof  in  1  qualified by pix_valid; marks the pixel as (0,0) of a new frame.
- pix_data  in  DATA_W  grayscale pixel.
- win_valid  out  1  window outputs valid this cycle (single-cycle strobe).
- win_last  out  1  with win_valid: last interior window of the frame, centre (IMG_W-2, IMG_H-2).
- win_x  out  $clog2(IMG_W)  column of the window centre.
- win_y  out  $clog2(IMG_H)  row of the window centre.
- data00..data22  out  DATA_W each  window; dataRC, R = row (0 = y-2, 2 = current line), C = column (0 = x-2, 2 = current column).

Behaviour:
- Reset (async assert, sync deassert internally): win_valid=0, win_last=0, win_x=0, win_y=0, all dataRC=0, column/row counters=0. Line buffer contents are don't-care.
- Counters:
  - x increments on each accepted pixel.
  - At x=IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), both wrap to 0, so a frame without sof rolls into the next frame.
- pix_valid && pix_sof forces the current pixel to be (0,0). Counters restart from it regardless of the prior position.
- Line buffers: two IMG_W-deep stores holding lines y-1 and y-2 at column x. Writes occur only on accepted pixels.
- Window shift: on each accepted pixel the 3x3 register array shifts one column left. The new right column is {line y-2[x], line y-1[x], pix_data}.
- Latency: one cycle. When a pixel at (x,y) is accepted with x>=2 and y>=2:
  - next cycle win_valid=1, win_x=x-1, win_y=y-1;
  - data22 = that pixel, data00 = pixel (x-2,y-2).
- Otherwise win_valid=0 the next cycle. Window contents are don't-care when win_valid=0.
- Windows never straddle lines. Columns shifted in from the previous line are masked by the x>=2 gate.
- Windows never straddle frames. Rows from the previous frame are masked by the y>=2 gate.
- Count: exactly (IMG_W-2)*(IMG_H-2) win_valid strobes per complete frame.
- win_last=1 only together with win_valid at centre (IMG_W-2, IMG_H-2).
- pix_valid=0 cycles: all state holds and win_valid=0. Gaps of any length do not change window contents.
- sof mid-frame: the partial frame is abandoned. There are no further windows until the new frame's pixel (2,2) is accepted.
- pix_sof with pix_valid=0 is ignored.
- Arithmetic: unsigned counters, no saturation. Pixel data passes through unmodified, with no arithmetic on data.

Test Plan:
1. IMG_W=8, IMG_H=6; pixel=(y<<4)|x, sof on the first pixel, continuous valid.
   - First win_valid occurs 1 cycle after (2,2) is accepted: win_x=1, win_y=1, data00=0x00, data02=0x02, data11=0x11, data20=0x20, data22=0x22.
   - 24 strobes total; the last has win_last=1, centre (6,4), data22=0x57.
2. Same frame with pseudo-random pix_valid gaps (0-5 cycles) -> identical ordered window sequence and count 24; win_valid never asserted during gap cycles.
3. Assert sof after 20 pixels (at (4,2)) -> no win_valid from that point until the restarted frame's (2,2) is accepted; then data00=0x00 of the new frame.
4. Assert reset_n low mid-frame -> all outputs 0 immediately (asynchronously); after release, a sof frame behaves exactly as in scenario 1.
5. Two frames back-to-back with sof only on the first -> second frame wraps automatically and yields 24 windows identical to the first; no window mixes rows from both frames.
6. End-to-end with the Sobel stage, using a vertical step (x<4 -> 0, else 0x4000), IMG_W=8, IMG_H=6:
   - For centres x=3 and x=4 (every row), Sobel abs sum = 4*0x4000 = 65536 > 32000 -> sdata=1.
   - For all other centres, the sum is 0 -> sdata=0.
